// File: rtl/ejtag_pkg.sv
// Shared constants for the EJTAG processor-bus breakpoint unit.
//   - Channel register offsets (EJDI_ADDR[4:2])
//   - PBC control bit positions and the mask of implemented PBC bits
//   - Status register field positions
// Optional feature macro used by the importing modules: EJTAG_PMATCH_PASSCNT_EN.
package ejtag_pkg;

    // Channel register offsets
    localparam logic [2:0] RegPba  = 3'd0;
    localparam logic [2:0] RegPbm  = 3'd1;
    localparam logic [2:0] RegPbd  = 3'd2;
    localparam logic [2:0] RegPbdm = 3'd3;
    localparam logic [2:0] RegPbc  = 3'd4;
    localparam logic [2:0] RegPcnt = 3'd5;

    // PBC bit positions
    localparam int unsigned PbcBe  = 0;
    localparam int unsigned PbcTe  = 2;
    localparam int unsigned PbcRdm = 4;
    localparam int unsigned PbcWrm = 5;
    localparam int unsigned PbcDce = 6;
    localparam int unsigned PbcUco = 7;
    localparam logic [7:0]  PbcMask = 8'hF5;

    // Status register fields
    localparam int unsigned StatNchLsb = 24;
    localparam int unsigned StatNchW   = 4;

endpackage

// File: rtl/ejtag_pmatch_ch.sv
// One breakpoint channel: PBA/PBM/PBD/PBDM/PBC/PCNT registers, the qualify
// logic against the stage-1 bus snapshot, the optional pass counter and the
// registered hit flops.
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   reset_dis_i            suppresses hit flops (counter still runs)
//   wr_en_i, reg_sel_i     register write strobe for this channel / offset
//   wdata_i, rdata_o       write data / combinational read data for reg_sel_i
//   s1_*_i                 stage-1 captured transaction
//   hit_o, hit_be_o, hit_te_o  registered hit, hit with BE, hit with TE
// Macro: EJTAG_PMATCH_PASSCNT_EN enables the pass counter.
module ejtag_pmatch_ch
    import ejtag_pkg::*;
#(
    parameter int unsigned AW     = 32,
    parameter int unsigned PCNT_W = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          reset_dis_i,
    input  logic          wr_en_i,
    input  logic [2:0]    reg_sel_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o,
    input  logic          s1_valid_i,
    input  logic [AW-1:0] s1_addr_i,
    input  logic [31:0]   s1_data_i,
    input  logic          s1_rw_i,
    input  logic          s1_uc_i,
    output logic          hit_o,
    output logic          hit_be_o,
    output logic          hit_te_o
);

    logic [31:0] pba_q, pbm_q, pbd_q, pbdm_q;
    logic [7:0]  pbc_q;
    logic [31:0] pcnt_rd;
    logic        match, hit;
    logic        addr_ok, data_ok, uc_ok, dir_ok, en;
    logic        hit_q, hit_be_q, hit_te_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pba_q  <= '0;
            pbm_q  <= '1;
            pbd_q  <= '0;
            pbdm_q <= '1;
            pbc_q  <= '0;
        end else if (wr_en_i) begin
            case (reg_sel_i)
                RegPba:  pba_q  <= wdata_i;
                RegPbm:  pbm_q  <= wdata_i;
                RegPbd:  pbd_q  <= wdata_i;
                RegPbdm: pbdm_q <= wdata_i;
                RegPbc:  pbc_q  <= wdata_i[7:0] & PbcMask;
                default: ;
            endcase
        end
    end

    always_comb begin
        addr_ok = ((s1_addr_i ^ pba_q[AW-1:0]) & ~pbm_q[AW-1:0]) == '0;
        data_ok = ~pbc_q[PbcDce] | (((s1_data_i ^ pbd_q) & ~pbdm_q) == '0);
        uc_ok   = ~pbc_q[PbcUco] | s1_uc_i;
        dir_ok  = s1_rw_i ? pbc_q[PbcRdm] : pbc_q[PbcWrm];
        en      = pbc_q[PbcBe] | pbc_q[PbcTe];
        // Any register write to this channel discards the match being evaluated.
        match   = s1_valid_i & en & dir_ok & addr_ok & data_ok & uc_ok & ~wr_en_i;
    end

`ifdef EJTAG_PMATCH_PASSCNT_EN
    logic [PCNT_W-1:0] reload_q, cnt_q, cnt_d;
    logic              pcnt_wr;

    assign pcnt_wr = wr_en_i && (reg_sel_i == RegPcnt);

    always_comb begin
        hit   = 1'b0;
        cnt_d = cnt_q;
        if (pcnt_wr) begin
            cnt_d = wdata_i[PCNT_W-1:0];
        end else if (match) begin
            if (cnt_q == '0) begin
                hit   = 1'b1;
                cnt_d = reload_q;
            end else begin
                cnt_d = cnt_q - PCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            reload_q <= '0;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (pcnt_wr) reload_q <= wdata_i[PCNT_W-1:0];
        end
    end

    assign pcnt_rd = 32'(cnt_q);
`else
    assign hit     = match;
    assign pcnt_rd = '0;
`endif

    always_comb begin
        rdata_o = '0;
        case (reg_sel_i)
            RegPba:  rdata_o = pba_q;
            RegPbm:  rdata_o = pbm_q;
            RegPbd:  rdata_o = pbd_q;
            RegPbdm: rdata_o = pbdm_q;
            RegPbc:  rdata_o = {24'd0, pbc_q};
            RegPcnt: rdata_o = pcnt_rd;
            default: rdata_o = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hit_q    <= 1'b0;
            hit_be_q <= 1'b0;
            hit_te_q <= 1'b0;
        end else begin
            hit_q    <= hit & ~reset_dis_i;
            hit_be_q <= hit & pbc_q[PbcBe] & ~reset_dis_i;
            hit_te_q <= hit & pbc_q[PbcTe] & ~reset_dis_i;
        end
    end

    assign hit_o    = hit_q;
    assign hit_be_o = hit_be_q;
    assign hit_te_o = hit_te_q;

endmodule

// File: rtl/ejtag_pmatch_mc.sv
// Multi-channel processor-bus breakpoint unit. Snoops the local-bus stream,
// evaluates NUM_CH breakpoint channels and reports break/trace hits.
// Ports:
//   CORE_CLOCK, RESET_D1_R_N   clock, synchronous active-low reset
//   RESET_DIS                  suppresses hit outputs and status set
//   EJ_STROBE, EJDI_*          EJTAG slave register access
//   LBC_*                      snooped bus (LBC_MDATA doubles as write data)
//   EJPM_DATA                  registered read data
//   EJPM_BREAKHIT_R/TRACEHIT_R one-cycle break/trace pulses
//   EJPM_CHHIT_R               per-channel one-cycle hit pulses
// Macro: EJTAG_PMATCH_PASSCNT_EN enables per-channel pass counters.
module ejtag_pmatch_mc
    import ejtag_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned AW     = 32,
    parameter int unsigned PCNT_W = 8
) (
    input  logic              CORE_CLOCK,
    input  logic              RESET_D1_R_N,
    input  logic              RESET_DIS,
    input  logic              EJ_STROBE,
    input  logic              EJDI_SELPBS,
    input  logic              EJDI_SELPBRS,
    input  logic [7:2]        EJDI_ADDR,
    input  logic              EJDI_RW,
    input  logic [31:0]       LBC_MDATA,
    input  logic [31:0]       LBC_MADDR,
    input  logic              LBC_MRW,
    input  logic              LBC_MTOGGLE,
    input  logic              LBC_MUC,
    output logic [31:0]       EJPM_DATA,
    output logic              EJPM_BREAKHIT_R,
    output logic              EJPM_TRACEHIT_R,
    output logic [NUM_CH-1:0] EJPM_CHHIT_R
);

    logic              tog_q, s1_valid_q, s1_rw_q, s1_uc_q;
    logic [AW-1:0]     s1_addr_q;
    logic [31:0]       s1_data_q;
    logic              new_txn, wr, rd;
    logic [2:0]        ch_sel;
    logic [NUM_CH-1:0] ch_wr_en, ch_hit, ch_hit_be, ch_hit_te;
    logic [31:0]       ch_rdata [NUM_CH];
    logic [NUM_CH-1:0] bs_q, bs_d, bs_clr;
    logic [31:0]       status, rd_d, data_q;

    assign new_txn = LBC_MTOGGLE ^ tog_q;
    assign wr      = EJ_STROBE & ~EJDI_RW;
    assign rd      = EJ_STROBE & EJDI_RW;
    assign ch_sel  = EJDI_ADDR[7:5];

    // Stage 1: toggle history and transaction capture.
    always_ff @(posedge CORE_CLOCK) begin
        if (!RESET_D1_R_N) begin
            tog_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_data_q  <= '0;
            s1_rw_q    <= 1'b0;
            s1_uc_q    <= 1'b0;
        end else begin
            tog_q      <= LBC_MTOGGLE;
            s1_valid_q <= new_txn;
            if (new_txn) begin
                s1_addr_q <= LBC_MADDR[AW-1:0];
                s1_data_q <= LBC_MDATA;
                s1_rw_q   <= LBC_MRW;
                s1_uc_q   <= LBC_MUC;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
        assign ch_wr_en[g] = wr & EJDI_SELPBRS & (ch_sel == 3'(g));

        ejtag_pmatch_ch #(
            .AW     (AW),
            .PCNT_W (PCNT_W)
        ) u_ch (
            .clk_i       (CORE_CLOCK),
            .rst_ni      (RESET_D1_R_N),
            .reset_dis_i (RESET_DIS),
            .wr_en_i     (ch_wr_en[g]),
            .reg_sel_i   (EJDI_ADDR[4:2]),
            .wdata_i     (LBC_MDATA),
            .rdata_o     (ch_rdata[g]),
            .s1_valid_i  (s1_valid_q),
            .s1_addr_i   (s1_addr_q),
            .s1_data_i   (s1_data_q),
            .s1_rw_i     (s1_rw_q),
            .s1_uc_i     (s1_uc_q),
            .hit_o       (ch_hit[g]),
            .hit_be_o    (ch_hit_be[g]),
            .hit_te_o    (ch_hit_te[g])
        );
    end

    // Sticky status: a hit in the same cycle as a W1C of that bit keeps it set.
    always_comb begin
        bs_clr = (wr & EJDI_SELPBS) ? LBC_MDATA[NUM_CH-1:0] : '0;
        bs_d   = (bs_q & ~bs_clr) | ch_hit;
        status = '0;
        status[NUM_CH-1:0] = bs_q;
        status[StatNchLsb +: StatNchW] = StatNchW'(NUM_CH);
    end

    always_comb begin
        rd_d = '0;
        if (EJDI_SELPBS) begin
            rd_d = status;
        end else if (EJDI_SELPBRS) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_sel == 3'(i)) rd_d = ch_rdata[i];
            end
        end
    end

    always_ff @(posedge CORE_CLOCK) begin
        if (!RESET_D1_R_N) begin
            bs_q   <= '0;
            data_q <= '0;
        end else begin
            bs_q <= bs_d;
            if (rd) data_q <= rd_d;
        end
    end

    assign EJPM_DATA       = data_q;
    assign EJPM_CHHIT_R    = ch_hit;
    assign EJPM_BREAKHIT_R = |ch_hit_be;
    assign EJPM_TRACEHIT_R = |ch_hit_te;

endmodule
